// File: rtl/mlp_load_sequencer_if.sv
// mlp_load_sequencer_if: UART byte input, input-buffer write port and MLP start/done handshake.
interface mlp_load_sequencer_if #(
   parameter int ADDR_W = 4
);
   logic              i_rx_dv;
   logic [7:0]        i_rx_byte;
   logic              o_wr_en;
   logic [ADDR_W-1:0] o_wr_addr;
   logic [3:0]        o_wr_data;
   logic              o_start;
   logic              i_done;
   logic [3:0]        i_result;
   logic [3:0]        o_result;
   logic              o_result_valid;
   logic              o_timeout;
   logic              o_overrun;
   logic              o_bad_char;
   logic [ADDR_W-1:0] o_count;

   modport slave (
      input  i_rx_dv, i_rx_byte, i_done, i_result,
      output o_wr_en, o_wr_addr, o_wr_data, o_start, o_result, o_result_valid,
             o_timeout, o_overrun, o_bad_char, o_count
   );

   modport master (
      output i_rx_dv, i_rx_byte, i_done, i_result,
      input  o_wr_en, o_wr_addr, o_wr_data, o_start, o_result, o_result_valid,
             o_timeout, o_overrun, o_bad_char, o_count
   );
endinterface

// File: rtl/mlp_load_sequencer.sv
// mlp_load_sequencer: loads hex-encoded UART features into the MLP input buffer, starts inference and captures its result.
module mlp_load_sequencer #(
   parameter int N_INPUTS    = 16,
   parameter int ADDR_W      = 4,
   parameter int TIMEOUT_CYC = 65535
) (
   input logic                 CLOCK_50,
   input logic                 KEY,
   mlp_load_sequencer_if.slave bus
);
   localparam int                TW        = $clog2(TIMEOUT_CYC + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_INPUTS - 1);
   localparam logic [TW-1:0]     TMO_LAST  = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {LOAD, START, WAIT} state_t;

   state_t            r_state;
   logic [TW-1:0]     r_tmo;
   logic [ADDR_W-1:0] r_count;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [3:0]        r_wr_data;
   logic [3:0]        r_result;
   logic              r_wr_en;
   logic              r_start;
   logic              r_valid;
   logic              r_timeout;
   logic              r_overrun;
   logic              r_bad;
   logic              w_hex;
   logic              w_esc;
   logic [3:0]        w_nib;

   // Classify the incoming byte: hex digit (either letter case), ESC abort, or bad.
   always_comb begin
      w_esc = bus.i_rx_byte == 8'h1B;
      w_hex = (bus.i_rx_byte >= 8'h30 && bus.i_rx_byte <= 8'h39) ||
              (bus.i_rx_byte >= 8'h41 && bus.i_rx_byte <= 8'h46) ||
              (bus.i_rx_byte >= 8'h61 && bus.i_rx_byte <= 8'h66);
      w_nib = (bus.i_rx_byte <= 8'h39) ? bus.i_rx_byte[3:0] : bus.i_rx_byte[3:0] + 4'd9;
   end

   // Sequencer: LOAD collects a frame, START fires the MLP, WAIT captures the result or times out.
   always_ff @(posedge CLOCK_50 or negedge KEY) begin
      if (!KEY) begin
         r_state   <= LOAD;
         r_tmo     <= '0;
         r_count   <= '0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_result  <= '0;
         r_wr_en   <= 1'b0;
         r_start   <= 1'b0;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
         r_overrun <= 1'b0;
         r_bad     <= 1'b0;
      end else begin
         r_wr_en   <= 1'b0;
         r_start   <= 1'b0;
         r_overrun <= 1'b0;
         r_bad     <= 1'b0;
         case (r_state)
            LOAD: begin
               if (bus.i_rx_dv) begin
                  if (w_hex) begin
                     r_wr_en   <= 1'b1;
                     r_wr_addr <= r_count;
                     r_wr_data <= w_nib;
                     if (r_count == '0) begin
                        r_valid   <= 1'b0;
                        r_timeout <= 1'b0;
                     end
                     if (r_count == LAST_ADDR) begin
                        r_count <= '0;
                        r_state <= START;
                     end else begin
                        r_count <= r_count + 1'b1;
                     end
                  end else if (w_esc) begin
                     r_count <= '0;
                  end else begin
                     r_bad <= 1'b1;
                  end
               end
            end
            START: begin
               r_overrun <= bus.i_rx_dv;
               r_start   <= 1'b1;
               r_tmo     <= '0;
               r_state   <= WAIT;
            end
            WAIT: begin
               r_overrun <= bus.i_rx_dv;
               if (bus.i_done) begin
                  r_result <= bus.i_result;
                  r_valid  <= 1'b1;
                  r_state  <= LOAD;
               end else if (r_tmo == TMO_LAST) begin
                  r_timeout <= 1'b1;
                  r_state   <= LOAD;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            default: r_state <= LOAD;
         endcase
      end
   end

   assign bus.o_wr_en        = r_wr_en;
   assign bus.o_wr_addr      = r_wr_addr;
   assign bus.o_wr_data      = r_wr_data;
   assign bus.o_start        = r_start;
   assign bus.o_result       = r_result;
   assign bus.o_result_valid = r_valid;
   assign bus.o_timeout      = r_timeout;
   assign bus.o_overrun      = r_overrun;
   assign bus.o_bad_char     = r_bad;
   assign bus.o_count        = r_count;
endmodule

// File: tb/tb_mlp_load_sequencer.sv
// tb_mlp_load_sequencer: directed and random stimulus checked every cycle against a behavioural model.
module tb_mlp_load_sequencer;
   localparam int N  = 16;
   localparam int AW = 4;
   localparam int T  = 20;

   logic clk = 1'b0;
   logic key = 1'b1;
   int   checks = 0;
   int   errors = 0;

   mlp_load_sequencer_if #(.ADDR_W(AW)) bus ();

   mlp_load_sequencer #(.N_INPUTS(N), .ADDR_W(AW), .TIMEOUT_CYC(T)) dut (
      .CLOCK_50 (clk),
      .KEY      (key),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int hex_val(input logic [7:0] b);
      logic [7:0] l;
      l = b | 8'h20;
      if (b >= "0" && b <= "9") return int'(b) - 48;
      if (l >= "a" && l <= "f") return int'(l) - 97 + 10;
      return -1;
   endfunction

   // Behavioural model: features loaded so far, and cycles elapsed since the frame completed (-1 = loading).
   logic       e_wr_en = 0, e_start = 0, e_valid = 0, e_tmo = 0, e_over = 0, e_bad = 0;
   logic [3:0] e_addr = 0, e_data = 0, e_res = 0;
   int         m_cnt = 0, m_busy = -1, nib;

   always @(posedge clk or negedge key) begin
      if (!key) begin
         {e_wr_en, e_start, e_valid, e_tmo, e_over, e_bad} = '0;
         e_addr = 0; e_data = 0; e_res = 0; m_cnt = 0; m_busy = -1;
      end else begin
         {e_wr_en, e_start, e_over, e_bad} = '0;
         if (m_busy < 0) begin
            if (bus.i_rx_dv) begin
               nib = hex_val(bus.i_rx_byte);
               if (nib >= 0) begin
                  e_wr_en = 1; e_addr = 4'(m_cnt); e_data = 4'(nib);
                  if (m_cnt == 0) begin e_valid = 0; e_tmo = 0; end
                  m_cnt++;
                  if (m_cnt == N) begin m_cnt = 0; m_busy = 0; end
               end else if (bus.i_rx_byte == 8'h1B) m_cnt = 0;
               else e_bad = 1;
            end
         end else begin
            e_over = bus.i_rx_dv;
            if (m_busy == 0) begin e_start = 1; m_busy = 1; end
            else if (bus.i_done) begin e_res = bus.i_result; e_valid = 1; m_busy = -1; end
            else if (m_busy == T) begin e_tmo = 1; m_busy = -1; end
            else m_busy++;
         end
      end
   end

   // Every cycle, all DUT outputs must match the model.
   always @(negedge clk) begin
      check("outputs",
         {10'd0, bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_start, bus.o_result,
          bus.o_result_valid, bus.o_timeout, bus.o_overrun, bus.o_bad_char, bus.o_count},
         {10'd0, e_wr_en, e_addr, e_data, e_start, e_res, e_valid, e_tmo, e_over, e_bad, 4'(m_cnt)});
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      bus.i_rx_dv   = 1'b1;
      bus.i_rx_byte = b;
      cyc();
      bus.i_rx_dv   = 1'b0;
   endtask

   task automatic wait_start();
      int n = 0;
      while (!bus.o_start && n < 50) begin
         cyc();
         n++;
      end
      check("start_seen", 32'(bus.o_start), 1);
   endtask

   task automatic send_rand_hex(input int cnt);
      string hx = "0123456789ABCDEFabcdef";
      for (int i = 0; i < cnt; i++) send(hx[$urandom_range(21, 0)]);
   endtask

   string frame = "0123456789ABCDEF";
   string hx    = "0123456789ABCDEFabcdef";

   initial begin
      bus.i_rx_dv = 0; bus.i_rx_byte = 0; bus.i_done = 0; bus.i_result = 0;
      #1 key = 1'b0;
      repeat (3) @(posedge clk);
      #1 key = 1'b1;
      check("reset_count", 32'(bus.o_count), 0);
      check("reset_valid", 32'(bus.o_result_valid), 0);
      cyc();
      // Full frame
      for (int i = 0; i < N; i++) begin
         send(frame[i]);
         if (i == 0) check("first_write", {bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data}, {1'b1, 4'd0, 4'd0});
      end
      check("last_write", {bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data}, {1'b1, 4'd15, 4'd15});
      cyc();
      check("start_pulse", {bus.o_start, bus.o_wr_en}, 2'b10);
      cyc();
      check("start_once", 32'(bus.o_start), 0);
      cyc();
      cyc();
      bus.i_done = 1; bus.i_result = 4'd7;
      cyc();
      bus.i_done = 0;
      check("result", {bus.o_result_valid, bus.o_result}, {1'b1, 4'd7});
      send("9");
      check("valid_cleared", {bus.o_result_valid, bus.o_wr_addr, bus.o_wr_data}, {1'b0, 4'd0, 4'd9});
      // Timeout with an overrun byte during WAIT
      send_rand_hex(N - 1);
      wait_start();
      send("A");
      check("overrun", {bus.o_overrun, bus.o_wr_en}, 2'b10);
      repeat (18) cyc();
      check("no_timeout_yet", 32'(bus.o_timeout), 0);
      cyc();
      check("timeout", {bus.o_timeout, bus.o_result, bus.o_count}, {1'b1, 4'd7, 4'd0});
      // Done coinciding with timeout expiry
      send_rand_hex(N);
      wait_start();
      repeat (19) cyc();
      bus.i_done = 1; bus.i_result = 4'd3;
      cyc();
      bus.i_done = 0;
      check("coincide", {bus.o_result_valid, bus.o_timeout, bus.o_result}, {1'b1, 1'b0, 4'd3});
      // Filtering
      send("5");
      check("filter_5", {bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data}, {1'b1, 4'd0, 4'd5});
      send("Z");
      check("filter_Z", {bus.o_bad_char, bus.o_wr_en, bus.o_count}, {1'b1, 1'b0, 4'd1});
      send(8'h1B);
      check("filter_esc", {bus.o_bad_char, bus.o_wr_en, bus.o_count}, {1'b0, 1'b0, 4'd0});
      send("a");
      check("filter_a", {bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_count}, {1'b1, 4'd0, 4'd10, 4'd1});
      // Reset mid-frame
      send_rand_hex(8);
      check("nine_loaded", 32'(bus.o_count), 9);
      key = 1'b0;
      #2;
      check("async_reset", {bus.o_count, bus.o_wr_en}, {4'd0, 1'b0});
      cyc();
      #2 key = 1'b1;
      cyc();
      send("C");
      check("after_reset", {bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data}, {1'b1, 4'd0, 4'd12});
      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         bus.i_rx_dv = ($urandom_range(2, 0) == 0);
         case ($urandom_range(19, 0))
            14:      bus.i_rx_byte = 8'h1B;
            15, 16:  bus.i_rx_byte = 8'($urandom);
            default: bus.i_rx_byte = hx[$urandom_range(21, 0)];
         endcase
         bus.i_done   = ($urandom_range(11, 0) == 0);
         bus.i_result = 4'($urandom);
         if ($urandom_range(599, 0) == 0) key = 1'b0;
         cyc();
         key = 1'b1;
      end
      bus.i_rx_dv = 0; bus.i_done = 0;
      repeat (3) cyc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mlp_load_sequencer.md
MLP_LOAD_SEQUENCER -- requirements
Module: mlp_load_sequencer

Interface
REQ-001 SHALL have parameter N_INPUTS, 16, number of 4-bit input features per frame (2..2^ADDR_W).
REQ-002 SHALL have parameter ADDR_W, 4, input-buffer address width.
REQ-003 SHALL have parameter TIMEOUT_CYC, 65535, maximum cycles to wait for the MLP done pulse.
REQ-004 SHALL have the following ports, with one clock and an asynchronous, active-low reset:
- CLOCK_50  in  1  sole clock, all state changes on its rising edge
- KEY  in  1  asynchronous active-low reset
- i_rx_dv  in  1  one-cycle strobe: i_rx_byte valid
- i_rx_byte  in  8  received UART byte
- o_wr_en  out  1  input-buffer write strobe
- o_wr_addr  out  ADDR_W  input-buffer write address
- o_wr_data  out  4  input-buffer write data
- o_start  out  1  one-cycle MLP start pulse
- i_done  in  1  one-cycle MLP completion pulse
- i_result  in  4  MLP classification, valid with i_done
- o_result  out  4  captured classification
- o_result_valid  out  1  o_result holds a fresh result
- o_timeout  out  1  last inference timed out
- o_overrun  out  1  one-cycle pulse: byte dropped while busy
- o_bad_char  out  1  one-cycle pulse: non-hex byte ignored
- o_count  out  ADDR_W  features loaded in the current frame

Function
REQ-005 SHALL implement the states LOAD, START and WAIT, all registered.
REQ-006 SHALL decode bytes as follows: 0x30-0x39 -> 0-9; 0x41-0x46 and 0x61-0x66 -> 10-15; 0x1B -> ABORT; any other byte -> bad.
REQ-007 In LOAD, on i_rx_dv with a hex byte, SHALL do all of the following on the next cycle:
- assert o_wr_en for exactly one cycle
- drive o_wr_addr = o_count (pre-increment) and o_wr_data = decoded nibble
- increment o_count
REQ-008 In LOAD, on the first accepted hex byte of a frame, SHALL clear o_result_valid and o_timeout in that same cycle.
REQ-009 SHALL move LOAD -> START in the cycle after the write of address N_INPUTS-1, and clear o_count to 0 in that transition.
REQ-010 In START, SHALL assert o_start for exactly one cycle, then go to WAIT and clear the timeout counter.
REQ-011 In WAIT, on i_done, SHALL on the next edge:
- register o_result = i_result
- set o_result_valid = 1
- return to LOAD
REQ-012 In WAIT, SHALL increment the timeout counter each cycle without i_done; when it reaches TIMEOUT_CYC it SHALL set o_timeout = 1, leave o_result unchanged and return to LOAD.
REQ-013 If i_done and timeout expiry coincide in the same cycle, SHALL treat it as done (REQ-011) and leave o_timeout = 0.
REQ-014 An ABORT byte in LOAD SHALL set o_count = 0 with no write, so the next hex byte writes address 0.
REQ-015 A bad byte in LOAD SHALL pulse o_bad_char one cycle later, with no write and o_count unchanged.
REQ-016 Any i_rx_dv in START or WAIT SHALL pulse o_overrun one cycle later; the byte SHALL be dropped, ABORT included.
REQ-017 SHALL never assert o_wr_en and o_start in the same cycle.
REQ-018 i_done outside WAIT SHALL be ignored.
REQ-019 All outputs SHALL be registered; o_result_valid and o_timeout SHALL be levels; o_wr_en, o_start, o_overrun and o_bad_char SHALL be single-cycle pulses.

Reset
REQ-020 KEY = 0 SHALL, asynchronously:
- set state = LOAD
- set o_count = 0 and clear the timeout counter
- set o_result = 0
- deassert o_result_valid, o_timeout, o_wr_en, o_start, o_overrun and o_bad_char
- set o_wr_addr = 0 and o_wr_data = 0
REQ-021 Reset mid-frame or during WAIT SHALL discard partial input; a late i_done after reset release SHALL be ignored per REQ-018.
REQ-022 Release of KEY SHALL take effect on the first CLOCK_50 edge after deassertion, with no spurious pulses.

Verification
REQ-023 SHALL cover:
- Full frame: send "0123456789ABCDEF" -> 16 writes, addr 0..15 with data 0..15; o_start pulses once, 1 cycle after the last write.
- Result: i_done with i_result = 7 three cycles after o_start -> o_result = 7, o_result_valid = 1; the next hex byte clears o_result_valid.
- Timeout: TIMEOUT_CYC = 20, no i_done -> o_timeout = 1 after 20 WAIT cycles, state back to LOAD, o_result unchanged.
- Filtering: "5", "Z", ESC, "a" -> one bad_char pulse; writes addr0 = 5, then addr0 = 10; o_count ends at 1.
- Overrun and coincidence: a byte during WAIT -> o_overrun pulse, no write; i_done in the timeout-expiry cycle -> o_result_valid = 1, o_timeout = 0.
- Reset: KEY low after 9 bytes -> o_count = 0 immediately; the next frame starts writing at addr 0.
